apb_uart_fifo: RTL and testbench

Parametrised APB UART slave: full APB3 access-phase handling, programmable baud divisor, TX/RX FIFOs of configurable depth, sticky error flags, and one maskable interrupt.
Replaces the fixed-width UART wrapper on the peripheral bus.
Register map is decoded on paddr_i, so software sees a self-contained block.

---
 rtl/apb_uart_fifo_pkg.sv | 50 +++++
 rtl/uart_sync_fifo.sv | 52 +++++
 rtl/apb_uart_fifo.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_apb_uart_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_fifo_pkg.sv
// Shared constants and FSM encodings for the APB UART with TX/RX FIFOs.
// APB_UART_LOOPBACK_EN adds CTRL[4] internal loopback.
package apb_uart_fifo_pkg;

    localparam int unsigned OFF_CTRL   = 32'h00;
    localparam int unsigned OFF_BAUD   = 32'h04;
    localparam int unsigned OFF_TXDATA = 32'h08;
    localparam int unsigned OFF_RXDATA = 32'h0C;
    localparam int unsigned OFF_STATUS = 32'h10;
    localparam int unsigned OFF_IEN    = 32'h14;

    localparam int unsigned CTRL_TX_EN   = 0;
    localparam int unsigned CTRL_RX_EN   = 1;
    localparam int unsigned CTRL_PAR_EN  = 2;
    localparam int unsigned CTRL_PAR_ODD = 3;
    localparam int unsigned CTRL_LOOP    = 4;

`ifdef APB_UART_LOOPBACK_EN
    localparam int unsigned CTRL_W = CTRL_LOOP + 1;
`else
    localparam int unsigned CTRL_W = CTRL_PAR_ODD + 1;
`endif

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_FULL  = 2;
    localparam int unsigned ST_RX_EMPTY = 3;
    localparam int unsigned ST_OVERRUN  = 4;
    localparam int unsigned ST_FRAME    = 5;
    localparam int unsigned ST_PARITY   = 6;

    localparam logic [15:0] MIN_BAUD = 16'd4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is taken only when a pop happens on the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB3 UART slave: register file, TX/RX FIFOs, TX/RX bit engines, interrupt.
// Define APB_UART_LOOPBACK_EN to add CTRL[4] internal TX->RX loopback.
module apb_uart_fifo
    import apb_uart_fifo_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DATA_BITS  = 8,
    parameter logic [15:0] DEF_BAUD   = 16'd868,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic              pclk_i,
    input  logic              prst_ni,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic              rx_i,
    output logic              tx_o,
    output logic              irq_o
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic                 access, wr, rd, w1c;
    logic [ADDR_W-1:0]    addr;
    logic                 sel_ctrl, sel_baud, sel_tx;
    logic                 sel_rx, sel_st, sel_ien, mapped;
    logic [CTRL_W-1:0]    ctrl;
    logic [15:0]          baud;
    logic [6:0]           ien;
    logic                 ovr, ferr, perr, irq_q;
    logic                 set_ovr, set_ferr, set_perr;
    logic                 tx_full, tx_empty, rx_full, rx_empty;
    logic [LW-1:0]        tx_level, rx_level;
    logic [DATA_BITS-1:0] tx_rdata, rx_rdata;
    logic                 tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0]          status;
    logic                 unused_bits;

    assign pready_o = 1'b1;
    assign access   = psel_i & penable_i;
    assign wr       = access & pwrite_i;
    assign rd       = access & ~pwrite_i;
    assign addr     = {paddr_i[ADDR_W-1:2], 2'b00};
    assign sel_ctrl = addr == ADDR_W'(OFF_CTRL);
    assign sel_baud = addr == ADDR_W'(OFF_BAUD);
    assign sel_tx   = addr == ADDR_W'(OFF_TXDATA);
    assign sel_rx   = addr == ADDR_W'(OFF_RXDATA);
    assign sel_st   = addr == ADDR_W'(OFF_STATUS);
    assign sel_ien  = addr == ADDR_W'(OFF_IEN);
    assign mapped   = sel_ctrl | sel_baud | sel_tx
                    | sel_rx | sel_st | sel_ien;
    assign w1c      = wr & sel_st;

    assign pslverr_o = access & (~mapped
                     | (sel_rx & pwrite_i)
                     | (sel_tx & ~pwrite_i)
                     | (sel_tx & pwrite_i & tx_full));

    assign tx_push = wr & sel_tx & ~tx_full;
    assign rx_pop  = rd & sel_rx & ~rx_empty;
    assign irq_o   = irq_q;

    assign unused_bits = ^{pwdata_i[31:16], paddr_i[1:0]};

    always_comb begin
        status = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_OVERRUN]  = ovr;
        status[ST_FRAME]    = ferr;
        status[ST_PARITY]   = perr;
        status[15:8]        = 8'(tx_level);
        status[23:16]       = 8'(rx_level);
    end

    always_comb begin
        prdata_o = '0;
        if (rd) begin
            unique case (1'b1)
                sel_ctrl: prdata_o = 32'(ctrl);
                sel_baud: prdata_o = {16'h0, baud};
                sel_rx:   prdata_o = rx_empty ? '0 : 32'(rx_rdata);
                sel_st:   prdata_o = status;
                sel_ien:  prdata_o = {25'h0, ien};
                default:  prdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            ctrl <= '0;
            baud <= DEF_BAUD;
            ien  <= '0;
        end else if (wr) begin
            if (sel_ctrl) ctrl <= pwdata_i[CTRL_W-1:0];
            if (sel_baud) baud <= (pwdata_i[15:0] < MIN_BAUD)
                                  ? MIN_BAUD : pwdata_i[15:0];
            if (sel_ien)  ien  <= pwdata_i[6:0];
        end
    end

    // Setting an error wins over a W1C landing on the same cycle.
    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            ovr   <= 1'b0;
            ferr  <= 1'b0;
            perr  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ovr   <= set_ovr  | (ovr  & ~(w1c & pwdata_i[ST_OVERRUN]));
            ferr  <= set_ferr | (ferr & ~(w1c & pwdata_i[ST_FRAME]));
            perr  <= set_perr | (perr & ~(w1c & pwdata_i[ST_PARITY]));
            irq_q <= |(status[6:0] & ien);
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (pclk_i),
        .rst_n (prst_ni),
        .push  (tx_push),
        .pop   (tx_pop),
        .wdata (pwdata_i[DATA_BITS-1:0]),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    logic [DATA_BITS-1:0] rx_shift;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (pclk_i),
        .rst_n (prst_ni),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_shift),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // ---------------- transmitter ----------------
    tx_state_e            tx_state, tx_next;
    logic [15:0]          tx_cnt, tx_div;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_par_en, tx_line, tx_val;
    logic                 tx_go, tx_tick, tx_last;

    assign tx_go   = ctrl[CTRL_TX_EN] & ~tx_empty;
    assign tx_tick = tx_cnt == tx_div - 1'b1;
    assign tx_last = tx_bit == 3'(DATA_BITS - 1);

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) tx_state <= TX_IDLE;
        else          tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            TX_IDLE:  if (tx_go) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_last)
                          tx_next = tx_par_en ? TX_PAR : TX_STOP;
            TX_PAR:   if (tx_tick) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick)
                          tx_next = tx_go ? TX_START : TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_pop = tx_go & ((tx_state == TX_IDLE)
               | ((tx_state == TX_STOP) & tx_tick));
        unique case (tx_state)
            TX_START: tx_val = 1'b0;
            TX_DATA:  tx_val = tx_shift[0];
            TX_PAR:   tx_val = tx_par;
            default:  tx_val = 1'b1;
        endcase
    end

    // Divisor and parity mode are frozen for the whole character.
    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            tx_cnt    <= '0;
            tx_div    <= DEF_BAUD;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_par_en <= 1'b0;
            tx_line   <= 1'b1;
        end else begin
            tx_line <= tx_val;
            if (tx_pop) begin
                tx_cnt    <= '0;
                tx_div    <= baud;
                tx_bit    <= '0;
                tx_shift  <= tx_rdata;
                tx_par    <= (^tx_rdata) ^ ctrl[CTRL_PAR_ODD];
                tx_par_en <= ctrl[CTRL_PAR_EN];
            end else if (tx_state != TX_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- receiver ----------------
    logic rx_src;

`ifdef APB_UART_LOOPBACK_EN
    assign tx_o   = ctrl[CTRL_LOOP] ? 1'b1 : tx_line;
    assign rx_src = ctrl[CTRL_LOOP] ? tx_line : rx_i;
`else
    assign tx_o   = tx_line;
    assign rx_src = rx_i;
`endif

    rx_state_e   rx_state, rx_next;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bit;
    logic        rx_s1, rx_s2, rx_prev;
    logic        rx_pbit, rx_par_en, rx_par_odd;
    logic        rx_en, rx_fall, rx_tick, rx_half, rx_last;
    logic        rx_done, rx_par_ok;

    assign rx_en   = ctrl[CTRL_RX_EN];
    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_tick = rx_cnt == rx_div - 1'b1;
    assign rx_half = rx_cnt == (rx_div >> 1);
    assign rx_last = rx_bit == 3'(DATA_BITS - 1);

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_s1    <= rx_src;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        if (!rx_en) begin
            rx_next = RX_IDLE;
        end else begin
            unique case (rx_state)
                RX_IDLE:  if (rx_fall) rx_next = RX_START;
                RX_START: if (rx_half)
                              rx_next = rx_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:  if (rx_tick && rx_last)
                              rx_next = rx_par_en ? RX_PAR : RX_STOP;
                RX_PAR:   if (rx_tick) rx_next = RX_STOP;
                RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
                default:  rx_next = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_done   = rx_en & (rx_state == RX_STOP) & rx_tick;
        rx_par_ok = ~rx_par_en
                  | (rx_pbit == ((^rx_shift) ^ rx_par_odd));
        set_ferr  = rx_done & ~rx_s2;
        set_perr  = rx_done & rx_s2 & ~rx_par_ok;
        rx_push   = rx_done & rx_s2 & rx_par_ok;
        set_ovr   = rx_push & rx_full & ~rx_pop;
    end

    always_ff @(posedge pclk_i or negedge prst_ni) begin
        if (!prst_ni) begin
            rx_cnt     <= '0;
            rx_div     <= DEF_BAUD;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_pbit    <= 1'b0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE) begin
                rx_cnt     <= '0;
                rx_div     <= baud;
                rx_bit     <= '0;
                rx_par_en  <= ctrl[CTRL_PAR_EN];
                rx_par_odd <= ctrl[CTRL_PAR_ODD];
            end else if ((rx_state == RX_START && rx_half)
                         || rx_tick) begin
                rx_cnt <= '0;
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
            if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_state == RX_PAR && rx_tick) rx_pbit <= rx_s2;
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Scoreboard bench for apb_uart_fifo: register map, TX framing/timing,
// FIFO limits, RX receive, frame/parity/overrun flags and interrupt.
module tb_apb_uart_fifo;

    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_BAUD = 12'h004;
    localparam logic [11:0] A_TXD  = 12'h008;
    localparam logic [11:0] A_RXD  = 12'h00C;
    localparam logic [11:0] A_STAT = 12'h010;
    localparam logic [11:0] A_IEN  = 12'h014;
    localparam logic [11:0] A_BAD  = 12'h018;

    logic        pclk = 1'b0;
    logic        prst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        rx = 1'b1;
    logic        tx;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] rdv;
    logic        e;

    always #5 pclk = ~pclk;

    apb_uart_fifo dut (
        .pclk_i    (pclk),
        .prst_ni   (prst_n),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .rx_i      (rx),
        .tx_o      (tx),
        .irq_o     (irq)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apb(input logic w, input logic [11:0] a,
                       input logic [31:0] d, output logic [31:0] r,
                       output logic err);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w;
        paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        #3;
        r = prdata;
        err = pslverr;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d,
                      output logic err);
        logic [31:0] r;
        apb(1'b1, a, d, r, err);
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] r,
                      output logic err);
        apb(1'b0, a, 32'h0, r, err);
    endtask

    task automatic rx_pop_check();
        logic [31:0] r;
        logic        err;
        rd(A_RXD, r, err);
        check("rx_rd_err", 32'(err), 32'd0);
        if (rx_q.size() == 0) check("rx_sb_empty", 32'd1, 32'd0);
        else check("rx_data", r, 32'(rx_q.pop_front()));
    endtask

    task automatic tx_capture(input int baud, input int nchars);
        int t;
        logic [9:0] bits;
        t = 0;
        while (tx !== 1'b0 && t < 500) begin
            @(negedge pclk);
            t++;
        end
        if (t >= 500) begin
            check("tx_start_wait", 32'(tx), 32'd0);
            return;
        end
        for (int c = 0; c < nchars; c++) begin
            for (int i = 0; i < 10; i++) begin
                repeat (i == 0 ? baud / 2 : baud) @(negedge pclk);
                bits[i] = tx;
            end
            check("tx_start_bit", 32'(bits[0]), 32'd0);
            check("tx_stop_bit", 32'(bits[9]), 32'd1);
            if (tx_q.size() == 0) check("tx_sb_empty", 32'd1, 32'd0);
            else check("tx_data", 32'(bits[8:1]),
                       32'(tx_q.pop_front()));
            if (c < nchars - 1) begin
                @(negedge pclk);
                check("tx_stop_end", 32'(tx), 32'd1);
                @(negedge pclk);
                check("tx_b2b_start", 32'(tx), 32'd0);
            end
        end
    endtask

    task automatic drive_bit(input int baud, input logic b);
        rx = b;
        repeat (baud) @(posedge pclk);
        #1;
    endtask

    task automatic rx_send(input int baud, input logic [7:0] d,
                           input logic par_en, input logic pbit,
                           input logic stop);
        @(posedge pclk); #1;
        drive_bit(baud, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(baud, d[i]);
        if (par_en) drive_bit(baud, pbit);
        drive_bit(baud, stop);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        repeat (3) @(posedge pclk);
        #1 prst_n = 1'b1;
        @(negedge pclk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        check("pready", 32'(pready), 32'd1);
        rd(A_STAT, rdv, e); check("rst_status", rdv, 32'h0000_000A);
        rd(A_BAUD, rdv, e); check("rst_baud", rdv, 32'd868);
        rd(A_CTRL, rdv, e); check("rst_ctrl", rdv, 32'd0);
        rd(A_IEN, rdv, e);  check("rst_ien", rdv, 32'd0);
        check("idle_prdata", prdata, 32'd0);

        wr(A_BAUD, 32'd2, e);
        rd(A_BAUD, rdv, e); check("baud_min", rdv, 32'd4);

        // two back-to-back characters at 4 clocks per bit
        wr(A_TXD, 32'hA5, e); tx_q.push_back(8'hA5);
        check("txd_err0", 32'(e), 32'd0);
        wr(A_TXD, 32'h3C, e); tx_q.push_back(8'h3C);
        wr(A_CTRL, 32'h1, e);
        tx_capture(4, 2);
        rd(A_STAT, rdv, e); check("tx_drained", rdv, 32'h0000_000A);

        rd(A_TXD, rdv, e);  check("rd_txd_err", 32'(e), 32'd1);
        wr(A_RXD, 32'h1, e); check("wr_rxd_err", 32'(e), 32'd1);
        rd(A_BAD, rdv, e);  check("unmapped_err", 32'(e), 32'd1);
        check("unmapped_data", rdv, 32'd0);
        rd(A_RXD, rdv, e);  check("rx_empty_err", 32'(e), 32'd0);
        check("rx_empty_data", rdv, 32'd0);

        // fill the TX FIFO with the transmitter disabled
        wr(A_CTRL, 32'h0, e);
        repeat (30) @(posedge pclk);
        for (int i = 0; i < 9; i++) begin
            wr(A_TXD, 32'(i), e);
            check(i < 8 ? "tx_fill_ok" : "tx_full_err",
                  32'(e), i < 8 ? 32'd0 : 32'd1);
        end
        rd(A_STAT, rdv, e); check("tx_full_stat", rdv, 32'h0000_0809);
        wr(A_CTRL, 32'h1, e);
        repeat (400) @(posedge pclk);
        rd(A_STAT, rdv, e); check("tx_empty_stat", rdv, 32'h0000_000A);
        wr(A_CTRL, 32'h0, e);

        // receive one character at 16 clocks per bit
        wr(A_BAUD, 32'd16, e);
        wr(A_CTRL, 32'h2, e);
        rx_send(16, 8'h3C, 1'b0, 1'b0, 1'b1);
        rx_q.push_back(8'h3C);
        repeat (20) @(posedge pclk);
        rd(A_STAT, rdv, e); check("rx_one_stat", rdv, 32'h0001_0002);
        rx_pop_check();
        rd(A_STAT, rdv, e); check("rx_popped", rdv, 32'h0000_000A);

        // framing error raises the interrupt
        wr(A_IEN, 32'h20, e);
        rx_send(16, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge pclk);
        check("irq_frame", 32'(irq), 32'd1);
        rd(A_STAT, rdv, e); check("frame_stat", rdv, 32'h0000_002A);
        wr(A_STAT, 32'h20, e);
        repeat (2) @(negedge pclk);
        check("irq_clear", 32'(irq), 32'd0);
        rd(A_STAT, rdv, e); check("frame_clr", rdv, 32'h0000_000A);

        // even parity mismatch: 0x07 has odd weight, sent parity 0
        wr(A_CTRL, 32'h6, e);
        rx_send(16, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (20) @(posedge pclk);
        rd(A_STAT, rdv, e); check("par_stat", rdv, 32'h0000_004A);
        check("irq_masked", 32'(irq), 32'd0);
        wr(A_STAT, 32'h40, e);

        // nine valid characters: the ninth overruns
        for (int i = 0; i < 9; i++) begin
            d = 8'($urandom_range(0, 255));
            rx_send(16, d, 1'b1, ^d, 1'b1);
            if (i < 8) rx_q.push_back(d);
        end
        repeat (20) @(posedge pclk);
        rd(A_STAT, rdv, e); check("ovr_stat", rdv, 32'h0008_0016);
        for (int i = 0; i < 8; i++) rx_pop_check();
        rd(A_STAT, rdv, e); check("ovr_sticky", rdv, 32'h0000_001A);
        wr(A_STAT, 32'h10, e);
        rd(A_STAT, rdv, e); check("ovr_clr", rdv, 32'h0000_000A);

        // odd parity: 0x07 with parity bit 0 is valid
        wr(A_CTRL, 32'hE, e);
        rx_send(16, 8'h07, 1'b1, 1'b0, 1'b1);
        rx_q.push_back(8'h07);
        repeat (20) @(posedge pclk);
        rx_pop_check();
        rd(A_STAT, rdv, e); check("odd_par_stat", rdv, 32'h0000_000A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
